// File: rtl/tau_core_if.sv
// Memory and ALU bus of tau_core: the controller drives requests and
// operands, the core returns registered read data and ALU results.
interface tau_core_if #(
    parameter int ADDR_W = 12
);
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        in;
    logic [7:0]        out;
    logic [7:0]        A;
    logic [7:0]        B;
    logic [3:0]        opcode;
    logic [7:0]        result;
    logic              carry_out;

    modport master (
        output we, re, addr, in, A, B, opcode,
        input  out, result, carry_out
    );

    modport slave (
        input  we, re, addr, in, A, B, opcode,
        output out, result, carry_out
    );
endinterface

// File: rtl/tau_core.sv
// tau_core: byte memory with registered read port, gated by a tick strobe
// (every clock or every LSI_DIV clocks), plus a stateless 16-op 8-bit ALU.
module tau_core #(
    parameter int LSI_DIV = 32,
    parameter int ADDR_W  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        lsi_enable,
    output logic        tick,
    tau_core_if.slave   bus
);
    localparam int CNT_W = (LSI_DIV > 2) ? $clog2(LSI_DIV) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [CNT_W-1:0] div_cnt;
    logic [7:0]       mem [DEPTH];
    logic [7:0]       out_q;

    // Update strobe; forced low during reset so no access can slip through.
    always_comb begin
        tick = 1'b0;
        if (!reset && clk_enable) begin
            tick = lsi_enable ? (div_cnt == CNT_W'(LSI_DIV - 1)) : 1'b1;
        end
    end

    // Free-running divider, advances only while enabled; wraps naturally
    // because LSI_DIV is a power of two. Mode changes never clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (clk_enable) begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (tick && bus.we) begin
            mem[bus.addr] <= bus.in;
        end
    end

    // Registered read port; nonblocking semantics give read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 8'h00;
        end else if (tick && bus.re) begin
            out_q <= mem[bus.addr];
        end
    end

    assign bus.out = out_q;

    // Combinational ALU, independent of reset, enable and tick.
    always_comb begin
        logic [8:0] wide;
        wide          = 9'h000;
        bus.result    = 8'h00;
        bus.carry_out = 1'b0;
        case (bus.opcode)
            4'h0: begin
                wide          = {1'b0, bus.A} + {1'b0, bus.B};
                bus.result    = wide[7:0];
                bus.carry_out = wide[8];
            end
            4'h1: begin
                wide          = {1'b0, bus.A} - {1'b0, bus.B};
                bus.result    = wide[7:0];
                bus.carry_out = wide[8];
            end
            4'h2: bus.result = bus.A & bus.B;
            4'h3: bus.result = bus.A | bus.B;
            4'h4: bus.result = bus.A ^ bus.B;
            4'h5: bus.result = ~bus.A;
            4'h6: begin
                bus.result    = {bus.A[6:0], 1'b0};
                bus.carry_out = bus.A[7];
            end
            4'h7: begin
                bus.result    = {1'b0, bus.A[7:1]};
                bus.carry_out = bus.A[0];
            end
            4'h8: begin
                bus.result    = bus.A + 8'h01;
                bus.carry_out = (bus.A == 8'hFF);
            end
            4'h9: begin
                bus.result    = bus.A - 8'h01;
                bus.carry_out = (bus.A == 8'h00);
            end
            4'hA: bus.result = ~(bus.A & bus.B);
            4'hB: bus.result = ~(bus.A | bus.B);
            4'hC: bus.result = ~(bus.A ^ bus.B);
            4'hD: bus.result = bus.A;
            4'hE: bus.result = bus.B;
            default: begin
                bus.result    = {7'b0, (bus.A == bus.B)};
                bus.carry_out = (bus.A < bus.B);
            end
        endcase
    end
endmodule

// File: tb/tb_tau_core.sv
// Directed bench for tau_core: ALU vector table plus memory/tick sequences.
module tb_tau_core;
    localparam int LSI_DIV = 32;
    localparam int ADDR_W  = 12;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    logic lsi_enable;
    logic tick;

    int n_vec = 0;
    int n_bad = 0;

    tau_core_if #(.ADDR_W(ADDR_W)) bus ();

    tau_core #(.LSI_DIV(LSI_DIV), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .lsi_enable (lsi_enable),
        .tick       (tick),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
    } alu_vec_t;

    alu_vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: edge, then settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.we = 1'b1; bus.re = 1'b0; bus.addr = a; bus.in = d;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic mem_read(input logic [ADDR_W-1:0] a);
        bus.we = 1'b0; bus.re = 1'b1; bus.addr = a;
        cyc();
        bus.re = 1'b0;
    endtask

    initial begin
        int ticks;
        int first_tick;
        bit found;

        vecs[0]  = '{4'h0, 8'h01, 8'h02, 8'h03, 1'b0};
        vecs[1]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2]  = '{4'h1, 8'h01, 8'h02, 8'hFF, 1'b1};
        vecs[3]  = '{4'h1, 8'h05, 8'h03, 8'h02, 1'b0};
        vecs[4]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[5]  = '{4'h3, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[6]  = '{4'h4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[7]  = '{4'h5, 8'h5A, 8'h00, 8'hA5, 1'b0};
        vecs[8]  = '{4'h6, 8'h81, 8'h00, 8'h02, 1'b1};
        vecs[9]  = '{4'h7, 8'h81, 8'h00, 8'h40, 1'b1};
        vecs[10] = '{4'h8, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{4'h8, 8'h41, 8'h00, 8'h42, 1'b0};
        vecs[12] = '{4'h9, 8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[13] = '{4'hA, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        vecs[14] = '{4'hB, 8'hF0, 8'h3C, 8'h03, 1'b0};
        vecs[15] = '{4'hC, 8'hF0, 8'h3C, 8'h33, 1'b0};
        vecs[16] = '{4'hD, 8'h12, 8'h34, 8'h12, 1'b0};
        vecs[17] = '{4'hE, 8'h12, 8'h34, 8'h34, 1'b0};
        vecs[18] = '{4'hF, 8'h05, 8'h05, 8'h01, 1'b0};
        vecs[19] = '{4'hF, 8'h03, 8'h07, 8'h00, 1'b1};

        reset = 1'b1; clk_enable = 1'b0; lsi_enable = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.in = 8'h00;
        bus.A = 8'h00; bus.B = 8'h00; bus.opcode = 4'h0;
        repeat (3) cyc();
        check("reset_out", 32'(bus.out), 32'h00);
        check("reset_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        clk_enable = 1'b1;

        // Full speed: distinct addresses 0x000 and 0x800.
        mem_write(12'h000, 8'h01);
        mem_write(12'h800, 8'h02);
        mem_read(12'h000);
        check("read_000", 32'(bus.out), 32'h01);
        mem_read(12'h800);
        check("read_800", 32'(bus.out), 32'h02);

        // ALU vector table.
        foreach (vecs[i]) begin
            bus.A = vecs[i].a; bus.B = vecs[i].b; bus.opcode = vecs[i].op;
            #1;
            check($sformatf("alu_res_%0d", i), 32'(bus.result), 32'(vecs[i].res));
            check($sformatf("alu_c_%0d", i), 32'(bus.carry_out), 32'(vecs[i].c));
        end

        // clk_enable=0 blocks write and freezes out.
        mem_write(12'h010, 8'h55);
        mem_read(12'h000);
        clk_enable = 1'b0;
        bus.we = 1'b1; bus.re = 1'b1; bus.addr = 12'h010; bus.in = 8'hAA;
        #1;
        check("gated_tick", 32'(tick), 32'h0);
        repeat (3) cyc();
        check("gated_out_frozen", 32'(bus.out), 32'h01);
        bus.we = 1'b0; bus.re = 1'b0;
        clk_enable = 1'b1;
        mem_read(12'h010);
        check("gated_mem_kept", 32'(bus.out), 32'h55);

        // Read-before-write.
        mem_write(12'h005, 8'h11);
        bus.we = 1'b1; bus.re = 1'b1; bus.addr = 12'h005; bus.in = 8'h22;
        cyc();
        bus.we = 1'b0; bus.re = 1'b0;
        check("rbw_old", 32'(bus.out), 32'h11);
        mem_read(12'h005);
        check("rbw_new", 32'(bus.out), 32'h22);

        // Reset in the middle of a read.
        mem_write(12'h020, 8'h33);
        mem_read(12'h000);
        bus.re = 1'b1; bus.addr = 12'h800;
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_async", 32'(bus.out), 32'h00);
        check("rst_tick", 32'(tick), 32'h0);
        bus.re = 1'b0;

        // LSI mode from a clean divider; write held requested throughout.
        @(posedge clk);
        #1;
        lsi_enable = 1'b1;
        bus.we = 1'b1; bus.addr = 12'h020; bus.in = 8'h77;
        reset = 1'b0;
        #1;
        check("lsi_tick_at_0", 32'(tick), 32'h0);
        ticks = 0; first_tick = -1;
        for (int k = 1; k <= 2 * LSI_DIV; k++) begin
            cyc();
            if (tick) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
            end
        end
        bus.we = 1'b0;
        check("lsi_tick_count", 32'(ticks), 32'd2);
        check("lsi_first_tick", 32'(first_tick), 32'(LSI_DIV - 1));

        // LSI read: wait (bounded) for the tick, then one more edge.
        bus.re = 1'b1; bus.addr = 12'h020;
        found = 1'b0;
        for (int k = 0; k < LSI_DIV + 4 && !found; k++) begin
            if (tick) found = 1'b1;
            else cyc();
        end
        check("lsi_tick_seen", 32'(found), 32'h1);
        cyc();
        bus.re = 1'b0;
        check("lsi_write_landed", 32'(bus.out), 32'h77);

        // Back to full speed: data written before reset survives.
        lsi_enable = 1'b0;
        mem_read(12'h000);
        check("post_rst_000", 32'(bus.out), 32'h01);
        mem_read(12'h800);
        check("post_rst_800", 32'(bus.out), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
